instr_encoder: RTL and testbench

Packs RISC-V RV32I instruction fields into a 32-bit instruction word, the inverse of the immediate decode path. Used by the debug/instruction-injection path and by the test harness to produce instructions from field tuples.
- Immediates use the same convention as the decode stage: branch and JAL offsets are supplied WITHOUT the left shift (offset/2).
- Two-stage valid/ready pipeline: checks in S1, packing and output in S2.

---
 rtl/instr_encoder.sv | 185 ++++++++++++++++++
 tb/tb_instr_encoder.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// RV32I instruction packer: S1 registers fields and legality, S2 packs the word and drives the output.
// Optional ENC_STATS_EN adds saturating delivered/illegal counters.
module instr_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_opcode,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [CNT_W-1:0] cnt_ok,
  output logic [CNT_W-1:0] cnt_err
);
  localparam logic [6:0]  OP_R     = 7'b0110011;
  localparam logic [6:0]  OP_I     = 7'b0010011;
  localparam logic [6:0]  OP_LUI   = 7'b0110111;
  localparam logic [6:0]  OP_AUIPC = 7'b0010111;
  localparam logic [6:0]  OP_LOAD  = 7'b0000011;
  localparam logic [6:0]  OP_STORE = 7'b0100011;
  localparam logic [6:0]  OP_BR    = 7'b1100011;
  localparam logic [6:0]  OP_JAL   = 7'b1101111;
  localparam logic [6:0]  OP_JALR  = 7'b1100111;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        w_s1_adv;
  logic        w_s2_adv;
  logic        w_f7_rs_ok;
  logic        w_imm12_ok;
  logic        w_shamt_ok;
  logic        w_legal;
  logic [31:0] w_packed;

  logic        r_s1_valid;
  logic        r_s1_legal;
  logic [6:0]  r_s1_op;
  logic [2:0]  r_s1_f3;
  logic [6:0]  r_s1_f7;
  logic [4:0]  r_s1_rd;
  logic [4:0]  r_s1_rs1;
  logic [4:0]  r_s1_rs2;
  logic [31:0] r_s1_imm;

  logic        r_s2_valid;
  logic [31:0] r_out_instr;
  logic        r_out_err;

  assign w_s2_adv  = !r_s2_valid || out_ready;
  assign w_s1_adv  = !r_s1_valid || w_s2_adv;
  assign in_ready  = w_s1_adv;
  assign out_valid = r_s2_valid;
  assign out_instr = r_out_instr;
  assign out_err   = r_out_err;

  // Legality of the incoming request: opcode known and immediate fits its format.
  always_comb begin
    w_f7_rs_ok = (in_funct7 == 7'b0000000) || (in_funct7 == 7'b0100000);
    w_imm12_ok = (in_imm[31:11] == {21{in_imm[11]}});
    w_shamt_ok = (in_imm[31:5] == 27'd0);
    w_legal    = 1'b0;
    case (in_opcode)
      OP_R: w_legal = w_f7_rs_ok;
      OP_I: begin
        if (in_funct3 == 3'b001) begin
          w_legal = w_shamt_ok && (in_funct7 == 7'b0000000);
        end else if (in_funct3 == 3'b101) begin
          w_legal = w_shamt_ok && w_f7_rs_ok;
        end else begin
          w_legal = w_imm12_ok;
        end
      end
      OP_LOAD, OP_JALR, OP_STORE, OP_BR: w_legal = w_imm12_ok;
      OP_LUI, OP_AUIPC:                  w_legal = (in_imm[11:0] == 12'd0);
      OP_JAL:                            w_legal = (in_imm[31:19] == {13{in_imm[19]}});
      default:                           w_legal = 1'b0;
    endcase
  end

  // Stage 1: capture request fields and the legality verdict.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_s1_valid <= 1'b0;
      r_s1_legal <= 1'b0;
      r_s1_op    <= 7'd0;
      r_s1_f3    <= 3'd0;
      r_s1_f7    <= 7'd0;
      r_s1_rd    <= 5'd0;
      r_s1_rs1   <= 5'd0;
      r_s1_rs2   <= 5'd0;
      r_s1_imm   <= 32'd0;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_legal <= w_legal;
        r_s1_op    <= in_opcode;
        r_s1_f3    <= in_funct3;
        r_s1_f7    <= in_funct7;
        r_s1_rd    <= in_rd;
        r_s1_rs1   <= in_rs1;
        r_s1_rs2   <= in_rs2;
        r_s1_imm   <= in_imm;
      end
    end
  end

  // Field packing; B and J immediates arrive already halved.
  always_comb begin
    w_packed = NOP;
    case (r_s1_op)
      OP_R: w_packed = {r_s1_f7, r_s1_rs2, r_s1_rs1, r_s1_f3, r_s1_rd, r_s1_op};
      OP_I: begin
        if ((r_s1_f3 == 3'b001) || (r_s1_f3 == 3'b101)) begin
          w_packed = {r_s1_f7, r_s1_imm[4:0], r_s1_rs1, r_s1_f3, r_s1_rd, r_s1_op};
        end else begin
          w_packed = {r_s1_imm[11:0], r_s1_rs1, r_s1_f3, r_s1_rd, r_s1_op};
        end
      end
      OP_LOAD, OP_JALR: w_packed = {r_s1_imm[11:0], r_s1_rs1, r_s1_f3, r_s1_rd, r_s1_op};
      OP_STORE: w_packed = {r_s1_imm[11:5], r_s1_rs2, r_s1_rs1, r_s1_f3, r_s1_imm[4:0], r_s1_op};
      OP_BR: w_packed = {r_s1_imm[11], r_s1_imm[9:4], r_s1_rs2, r_s1_rs1, r_s1_f3,
                         r_s1_imm[3:0], r_s1_imm[10], r_s1_op};
      OP_LUI, OP_AUIPC: w_packed = {r_s1_imm[31:12], r_s1_rd, r_s1_op};
      OP_JAL: w_packed = {r_s1_imm[19], r_s1_imm[9:0], r_s1_imm[10], r_s1_imm[18:11],
                          r_s1_rd, r_s1_op};
      default: w_packed = NOP;
    endcase
  end

  // Stage 2: output register, held while the consumer stalls.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_s2_valid  <= 1'b0;
      r_out_instr <= 32'd0;
      r_out_err   <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_instr <= r_s1_legal ? w_packed : NOP;
        r_out_err   <= !r_s1_legal;
      end
    end
  end

`ifdef ENC_STATS_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] r_cnt_ok;
  logic [CNT_W-1:0] r_cnt_err;

  // Saturating counts of delivered legal and illegal requests.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt_ok  <= {CNT_W{1'b0}};
      r_cnt_err <= {CNT_W{1'b0}};
    end else if (r_s2_valid && out_ready) begin
      if (r_out_err) begin
        if (r_cnt_err != CNT_MAX) begin
          r_cnt_err <= r_cnt_err + CNT_ONE;
        end
      end else begin
        if (r_cnt_ok != CNT_MAX) begin
          r_cnt_ok <= r_cnt_ok + CNT_ONE;
        end
      end
    end
  end

  assign cnt_ok  = r_cnt_ok;
  assign cnt_err = r_cnt_err;
`else
  assign cnt_ok  = {CNT_W{1'b0}};
  assign cnt_err = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized bench for instr_encoder with a queue-based reference model.
module tb_instr_encoder;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [6:0]       in_opcode = 7'd0;
  logic [2:0]       in_funct3 = 3'd0;
  logic [6:0]       in_funct7 = 7'd0;
  logic [4:0]       in_rd = 5'd0;
  logic [4:0]       in_rs1 = 5'd0;
  logic [4:0]       in_rs2 = 5'd0;
  logic [31:0]      in_imm = 32'd0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_instr;
  logic             out_err;
  logic [CNT_W-1:0] cnt_ok;
  logic [CNT_W-1:0] cnt_err;

  instr_encoder #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_err(out_err), .cnt_ok(cnt_ok), .cnt_err(cnt_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic        err;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   m_ok = 0;
  int   m_err = 0;
  int   n_deliv = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: legality from numeric ranges, layout from byte offsets as in the ISA manual.
  function automatic logic [32:0] model(input logic [6:0] op, input logic [2:0] f3,
                                        input logic [6:0] f7, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2,
                                        input logic [31:0] imm);
    int          s;
    logic        ok;
    logic [31:0] w;
    logic [31:0] off;
    logic [31:0] regs;
    s    = $signed(imm);
    off  = imm << 1;
    regs = (32'(rs1) << 15) | (32'(f3) << 12) | 32'(op);
    ok   = 1'b0;
    w    = 32'h13;
    case (op)
      7'b0110011: begin
        ok = (f7 == 7'd0) || (f7 == 7'd32);
        w  = (32'(f7) << 25) | (32'(rs2) << 20) | regs | (32'(rd) << 7);
      end
      7'b0010011, 7'b0000011, 7'b1100111: begin
        if (op == 7'b0010011 && (f3 == 3'd1 || f3 == 3'd5)) begin
          ok = (imm < 32'd32) && ((f7 == 7'd0) || (f3 == 3'd5 && f7 == 7'd32));
          w  = (32'(f7) << 25) | ((imm & 32'd31) << 20) | regs | (32'(rd) << 7);
        end else begin
          ok = (s >= -2048) && (s <= 2047);
          w  = ((imm & 32'hFFF) << 20) | regs | (32'(rd) << 7);
        end
      end
      7'b0100011: begin
        ok = (s >= -2048) && (s <= 2047);
        w  = (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | regs | ((imm & 32'd31) << 7);
      end
      7'b1100011: begin
        ok = (s >= -2048) && (s <= 2047);
        w  = (((off >> 12) & 32'd1) << 31) | (((off >> 5) & 32'd63) << 25) | (32'(rs2) << 20)
           | regs | (((off >> 1) & 32'd15) << 8) | (((off >> 11) & 32'd1) << 7);
      end
      7'b0110111, 7'b0010111: begin
        ok = (imm % 32'd4096) == 32'd0;
        w  = imm | (32'(rd) << 7) | 32'(op);
      end
      7'b1101111: begin
        ok = (s >= -524288) && (s <= 524287);
        w  = (((off >> 20) & 32'd1) << 31) | (((off >> 1) & 32'd1023) << 21)
           | (((off >> 11) & 32'd1) << 20) | (((off >> 12) & 32'd255) << 12)
           | (32'(rd) << 7) | 32'(op);
      end
      default: ok = 1'b0;
    endcase
    return ok ? {1'b0, w} : {1'b1, 32'h0000_0013};
  endfunction

  // Cycle-by-cycle scoreboard compare on the falling edge.
  always @(negedge clk) begin
    if (rstn) begin
      chk("in_ready", {31'd0, in_ready}, (q.size() == 2 && !out_ready) ? 32'd0 : 32'd1);
      chk("out_valid", {31'd0, out_valid},
          (q.size() > 0 && cyc >= q[0].acc + 2) ? 32'd1 : 32'd0);
      if (out_valid && q.size() > 0) begin
        chk("out_instr", out_instr, q[0].instr);
        chk("out_err", {31'd0, out_err}, {31'd0, q[0].err});
      end
`ifdef ENC_STATS_EN
      chk("cnt_ok", 32'(cnt_ok), 32'(m_ok));
      chk("cnt_err", 32'(cnt_err), 32'(m_err));
`else
      chk("cnt_ok_tied", 32'(cnt_ok), 32'd0);
      chk("cnt_err_tied", 32'(cnt_err), 32'd0);
`endif
      if (out_valid && out_ready && q.size() > 0) begin
        if (q[0].err) m_err = (m_err < 65535) ? m_err + 1 : m_err;
        else          m_ok  = (m_ok < 65535) ? m_ok + 1 : m_ok;
        n_deliv++;
        void'(q.pop_front());
      end
      if (in_valid && in_ready) begin
        logic [32:0] r;
        exp_t e;
        r = model(in_opcode, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm);
        e.instr = r[31:0];
        e.err   = r[32];
        e.acc   = cyc;
        q.push_back(e);
      end
    end
  end

  task automatic set_req(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] imm);
    in_opcode = op; in_funct3 = f3; in_funct7 = f7;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
  endtask

  // One request into an empty pipeline with out_ready held high; checks N+1 and N+2.
  task automatic directed(input string name, input logic [6:0] op, input logic [2:0] f3,
                          input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [31:0] imm, input logic [31:0] exp_i, input logic exp_e);
    @(posedge clk); #1;
    out_ready = 1'b1;
    set_req(op, f3, 7'd0, rd, rs1, rs2, imm);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk({name, "_lat1"}, {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk({name, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({name, "_instr"}, out_instr, exp_i);
    chk({name, "_err"}, {31'd0, out_err}, {31'd0, exp_e});
  endtask

  logic [31:0] bnd [10] = '{32'd2047, 32'd2048, 32'hFFFF_F800, 32'hFFFF_F7FF, 32'd31,
                            32'd32, 32'h0007_FFFF, 32'h0008_0000, 32'hFFF8_0000, 32'hFFF7_FFFF};
  logic [6:0]  ops [11] = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b0000011,
                            7'b0100011, 7'b1100011, 7'b1101111, 7'b1100111, 7'b1111111,
                            7'b0001111};

  initial begin
    logic [31:0] t;
    int          sent;

    // Model pins against hand-encoded words.
    chk("model_addi", 32'(model(7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5)), 32'h0050_0093);
    chk("model_beq", 32'(model(7'b1100011, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd4)), 32'h0020_8463);
    chk("model_jal", 32'(model(7'b1101111, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFE)), 32'hFFDF_F06F);
    chk("model_lui_bad_err", {31'd0, model(7'b0110111, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5001) >> 32}, 32'd1);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_err", {31'd0, out_err}, 32'd0);
    rstn = 1'b1;

    directed("addi", 7'b0010011, 3'd0, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093, 1'b0);
    directed("beq", 7'b1100011, 3'd0, 5'd0, 5'd1, 5'd2, 32'd4, 32'h0020_8463, 1'b0);
    directed("jal", 7'b1101111, 3'd0, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFE, 32'hFFDF_F06F, 1'b0);
    directed("lui", 7'b0110111, 3'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0);
    directed("lui_bad", 7'b0110111, 3'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5001, 32'h0000_0013, 1'b1);
    directed("addi_2048", 7'b0010011, 3'd0, 5'd1, 5'd0, 5'd0, 32'd2048, 32'h0000_0013, 1'b1);
    directed("addi_m2048", 7'b0010011, 3'd0, 5'd1, 5'd0, 5'd0, 32'hFFFF_F800, 32'h8000_0093, 1'b0);

    // Fill both stages with the consumer stalled, then pulse reset.
    @(posedge clk); #1;
    out_ready = 1'b0;
    set_req(7'b0010011, 3'd0, 7'd0, 5'd3, 5'd0, 5'd0, 32'd7);
    in_valid = 1'b1;
    @(posedge clk); #1;
    set_req(7'b0010011, 3'd0, 7'd0, 5'd4, 5'd0, 5'd0, 32'd8);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    chk("pre_rst_ready", {31'd0, in_ready}, 32'd0);
    rstn = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_cnt_ok", 32'(cnt_ok), 32'd0);
    chk("rst_cnt_err", 32'(cnt_err), 32'd0);
    q.delete();
    m_ok = 0;
    m_err = 0;
    @(posedge clk); #1;
    rstn = 1'b1;

    // Five back-to-back requests with out_ready low in cycles 2..4.
    sent = 0;
    n_deliv = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      out_ready = !(c >= 2 && c <= 4);
      if (sent < 5) begin
        set_req(7'b0010011, 3'd0, 7'd0, 5'(sent + 1), 5'd2, 5'd0, 32'(sent * 3));
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (in_valid && in_ready) sent++;
    end
    chk("stream_sent", 32'(sent), 32'd5);
    chk("stream_delivered", 32'(n_deliv), 32'd5);
    chk("stream_empty", 32'(q.size()), 32'd0);
`ifdef ENC_STATS_EN
    chk("stream_cnt_ok", 32'(cnt_ok), 32'd5);
`endif

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      t = $urandom;
      in_opcode = ops[$urandom_range(0, 10)];
      in_funct3 = 3'($urandom);
      case ($urandom_range(0, 2))
        0:       in_funct7 = 7'd0;
        1:       in_funct7 = 7'h20;
        default: in_funct7 = 7'($urandom);
      endcase
      in_rd  = 5'($urandom);
      in_rs1 = 5'($urandom);
      in_rs2 = 5'($urandom);
      case ($urandom_range(0, 5))
        0:       in_imm = $urandom;
        1:       in_imm = {{20{t[11]}}, t[11:0]};
        2:       in_imm = {{12{t[19]}}, t[19:0]};
        3:       in_imm = {t[31:12], 12'h000};
        4:       in_imm = {27'd0, t[4:0]};
        default: in_imm = bnd[$urandom_range(0, 9)];
      endcase
    end

    // Drain with a bounded wait.
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    chk("drain_empty", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
